// File: rtl/bmm_scheduler.sv
// Tile sequencer for one bmm_partial multiplier: walks the SIZE x SIZE product one
// BLOCK_SIZE x BLOCK_SIZE output tile at a time and emits tiles row-major over valid/ready.
module bmm_scheduler #(
    parameter int unsigned BLOCK_SIZE = 2,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned SIZE       = 4,
    parameter int unsigned TIMEOUT    = 16,
    localparam int unsigned NB = SIZE / BLOCK_SIZE,
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1,
    localparam int unsigned OW = BLOCK_SIZE * SIZE * DATA_WIDTH,
    localparam int unsigned RW = BLOCK_SIZE * BLOCK_SIZE * DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err_timeout,
    output logic          a_rd_en,
    output logic [IW-1:0] a_rd_idx,
    input  logic [OW-1:0] a_rd_data,
    output logic          b_rd_en,
    output logic [IW-1:0] b_rd_idx,
    input  logic [OW-1:0] b_rd_data,
    output logic [OW-1:0] mm_A_rows,
    output logic [OW-1:0] mm_B_cols,
    output logic          mm_valid_in,
    input  logic          mm_valid_out,
    input  logic [RW-1:0] mm_AB_partial,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_data,
    output logic [IW-1:0] res_row,
    output logic [IW-1:0] res_col
);

    localparam int unsigned  CW      = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LastIdx = IW'(NB - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StIssue,
        StWait,
        StWrite,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [OW-1:0] a_rows_q, a_rows_d;
    logic [OW-1:0] b_cols_q, b_cols_d;
    logic [RW-1:0] res_data_q, res_data_d;
    logic [IW-1:0] res_row_q, res_row_d;
    logic [IW-1:0] res_col_q, res_col_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            a_rows_q   <= '0;
            b_cols_q   <= '0;
            res_data_q <= '0;
            res_row_q  <= '0;
            res_col_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            a_rows_q   <= a_rows_d;
            b_cols_q   <= b_cols_d;
            res_data_q <= res_data_d;
            res_row_q  <= res_row_d;
            res_col_q  <= res_col_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        a_rows_d   = a_rows_q;
        b_cols_d   = b_cols_q;
        res_data_d = res_data_q;
        res_row_d  = res_row_q;
        res_col_d  = res_col_q;

        // Abort freezes every register except the state, so err_timeout survives it.
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StFetch;
                        row_d   = '0;
                        col_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                StFetch: state_d = StLoad;
                StLoad: begin
                    a_rows_d = a_rd_data;
                    b_cols_d = b_rd_data;
                    state_d  = StIssue;
                end
                StIssue: begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
                StWait: begin
                    if (mm_valid_out) begin
                        res_data_d = mm_AB_partial;
                        res_row_d  = row_q;
                        res_col_d  = col_q;
                        state_d    = StWrite;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d == CW'(TIMEOUT)) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                StWrite: begin
                    if (res_ready) begin
                        if (row_q == LastIdx && col_q == LastIdx) begin
                            state_d = StDone;
                        end else begin
                            if (col_q == LastIdx) begin
                                col_d = '0;
                                row_d = row_q + IW'(1);
                            end else begin
                                col_d = col_q + IW'(1);
                            end
                            state_d = StFetch;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign err_timeout = err_q;
    assign a_rd_en     = (state_q == StFetch);
    assign b_rd_en     = (state_q == StFetch);
    assign a_rd_idx    = row_q;
    assign b_rd_idx    = col_q;
    assign mm_A_rows   = a_rows_q;
    assign mm_B_cols   = b_cols_q;
    assign mm_valid_in = (state_q == StIssue);
    assign res_valid   = (state_q == StWrite);
    assign res_data    = res_data_q;
    assign res_row     = res_row_q;
    assign res_col     = res_col_q;

endmodule

// File: tb/tb_bmm_scheduler.sv
// Bench for bmm_scheduler: operand buffers and a one-cycle multiplier stub around the DUT,
// tiles checked against a full-matrix reference product.
module tb_bmm_scheduler;

    localparam int BS = 2;
    localparam int DW = 4;
    localparam int SZ = 4;
    localparam int NB = SZ / BS;
    localparam int IW = 1;
    localparam int OW = BS * SZ * DW;
    localparam int RW = BS * BS * DW;

    typedef struct {
        logic [RW-1:0] data;
        int            row;
        int            col;
    } tile_t;

    logic          clk = 1'b0;
    logic          rst, start, abort, res_ready;
    logic          busy, done, err_timeout, a_rd_en, b_rd_en, mm_valid_in, mm_valid_out, res_valid;
    logic [IW-1:0] a_rd_idx, b_rd_idx, res_row, res_col;
    logic [OW-1:0] a_rd_data = '0;
    logic [OW-1:0] b_rd_data = '0;
    logic [OW-1:0] mm_A_rows, mm_B_cols;
    logic [RW-1:0] mm_AB_partial, res_data;

    logic          stub_en = 1'b1;
    logic          stub_v  = 1'b0;
    logic [RW-1:0] stub_p  = '0;

    int unsigned ma[SZ][SZ];
    int unsigned mb[SZ][SZ];
    tile_t       exp_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;

    bmm_scheduler #(
        .BLOCK_SIZE(BS),
        .DATA_WIDTH(DW),
        .SIZE      (SZ),
        .TIMEOUT   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .a_rd_en      (a_rd_en),
        .a_rd_idx     (a_rd_idx),
        .a_rd_data    (a_rd_data),
        .b_rd_en      (b_rd_en),
        .b_rd_idx     (b_rd_idx),
        .b_rd_data    (b_rd_data),
        .mm_A_rows    (mm_A_rows),
        .mm_B_cols    (mm_B_cols),
        .mm_valid_in  (mm_valid_in),
        .mm_valid_out (mm_valid_out),
        .mm_AB_partial(mm_AB_partial),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_row      (res_row),
        .res_col      (res_col)
    );

    always #5 clk = ~clk;

    // A row-block: element (r,k) at ((r*SZ+k)*DW); B col-block: element (k,c) at ((k*BS+c)*DW).
    function automatic logic [OW-1:0] pack_a(input logic [IW-1:0] idx);
        logic [OW-1:0] v;
        v = '0;
        for (int r = 0; r < BS; r++)
            for (int k = 0; k < SZ; k++)
                v[(r*SZ+k)*DW +: DW] = DW'(ma[int'(idx)*BS+r][k]);
        return v;
    endfunction

    function automatic logic [OW-1:0] pack_b(input logic [IW-1:0] idx);
        logic [OW-1:0] v;
        v = '0;
        for (int k = 0; k < SZ; k++)
            for (int c = 0; c < BS; c++)
                v[(k*BS+c)*DW +: DW] = DW'(mb[k][int'(idx)*BS+c]);
        return v;
    endfunction

    function automatic logic [RW-1:0] tile_mul(input logic [OW-1:0] ar, input logic [OW-1:0] bc);
        logic [RW-1:0] v;
        v = '0;
        for (int i = 0; i < BS; i++)
            for (int j = 0; j < BS; j++) begin
                int unsigned s;
                s = 0;
                for (int k = 0; k < SZ; k++)
                    s += int'(ar[(i*SZ+k)*DW +: DW]) * int'(bc[(k*BS+j)*DW +: DW]);
                v[(i*BS+j)*DW +: DW] = DW'(s);
            end
        return v;
    endfunction

    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= pack_a(a_rd_idx);
        if (b_rd_en) b_rd_data <= pack_b(b_rd_idx);
        stub_v <= mm_valid_in && stub_en;
        stub_p <= tile_mul(mm_A_rows, mm_B_cols);
    end

    assign mm_valid_out  = stub_v;
    assign mm_AB_partial = stub_p;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: full product C = A*B mod 2^DW, tiles queued row-major.
    task automatic build_expected();
        exp_q.delete();
        for (int tr = 0; tr < NB; tr++)
            for (int tc = 0; tc < NB; tc++) begin
                tile_t t;
                t.data = '0;
                t.row  = tr;
                t.col  = tc;
                for (int i = 0; i < BS; i++)
                    for (int j = 0; j < BS; j++) begin
                        int unsigned s;
                        s = 0;
                        for (int k = 0; k < SZ; k++) s += ma[tr*BS+i][k] * mb[k][tc*BS+j];
                        t.data[(i*BS+j)*DW +: DW] = DW'(s % (1 << DW));
                    end
                exp_q.push_back(t);
            end
    endtask

    task automatic randomize_mats();
        for (int i = 0; i < SZ; i++)
            for (int j = 0; j < SZ; j++) begin
                ma[i][j] = $urandom_range(0, 15);
                mb[i][j] = $urandom_range(0, 15);
            end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {busy, done, err_timeout, a_rd_en, b_rd_en, mm_valid_in, res_valid,
                              a_rd_idx, b_rd_idx, res_row, res_col}, '0);
        check({tag, "_res_data"}, res_data, '0);
        check({tag, "_a_rows"}, mm_A_rows, '0);
        check({tag, "_b_cols"}, mm_B_cols, '0);
    endtask

    // One full product. bp_tile/bp_len stall that tile; extra_start_t pulses start mid-run.
    task automatic run_full(input int bp_tile, input int bp_len, input int extra_start_t);
        int t, done_t, tiles, hold;
        bit stall_prev;
        build_expected();
        res_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("err_clear_on_start", err_timeout, 1'b0);
        done_t     = -1;
        tiles      = 0;
        hold       = 0;
        stall_prev = 1'b0;
        for (t = 0; t < 200 && done_t < 0; t++) begin
            start     = (extra_start_t >= 0 && t == extra_start_t);
            res_ready = 1'b1;
            if (extra_start_t >= 0 && t == extra_start_t + 1)
                check("busy_after_ignored_start", busy, 1'b1);
            if (stall_prev) check("bp_valid_held", res_valid, 1'b1);
            stall_prev = 1'b0;
            if (done) begin
                done_t = t;
            end else if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tile", res_valid, 1'b0);
                end else begin
                    check("tile_data", res_data, exp_q[0].data);
                    check("tile_row", res_row, exp_q[0].row);
                    check("tile_col", res_col, exp_q[0].col);
                    check("no_fetch_in_write", a_rd_en, 1'b0);
                    if (tiles == bp_tile && hold < bp_len) begin
                        res_ready  = 1'b0;
                        hold++;
                        stall_prev = 1'b1;
                    end else begin
                        void'(exp_q.pop_front());
                        tiles++;
                    end
                end
            end
            if (done_t < 0) tick();
        end
        start     = 1'b0;
        res_ready = 1'b1;
        check("done_cycle", done_t, NB * NB * 5 + bp_len);
        check("tiles_remaining", exp_q.size(), 0);
        tick();
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        bit seen_done;
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // A = I, B = 0..15 row-major: tiles are the B sub-blocks, done 20 cycles after start.
        for (int i = 0; i < SZ; i++)
            for (int j = 0; j < SZ; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = i * SZ + j;
            end
        run_full(-1, 0, -1);

        randomize_mats();
        run_full(1, 3, 7);
        for (int n = 0; n < 3; n++) begin
            randomize_mats();
            run_full(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), -1);
        end

        // Multiplier never answers: abort after 16 WAIT cycles.
        stub_en   = 1'b0;
        seen_done = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 26; t++) begin
            if (done) seen_done = 1'b1;
            if (t == 18) begin
                check("to_busy_last_wait", busy, 1'b1);
                check("to_err_not_yet", err_timeout, 1'b0);
            end
            if (t == 19) begin
                check("to_idle", busy, 1'b0);
                check("to_err_set", err_timeout, 1'b1);
            end
            tick();
        end
        check("to_no_done", seen_done, 1'b0);
        stub_en = 1'b1;

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle_busy", busy, 1'b0);
        check("start_abort_err_kept", err_timeout, 1'b1);
        randomize_mats();
        run_full(-1, 0, -1);

        // Abort in WAIT of tile (1,0), then restart from (0,0).
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 13; t++) tick();
        check("abort_pre_busy", busy, 1'b1);
        check("abort_pre_in_wait", {res_valid, mm_valid_in, a_rd_en}, 3'b000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", busy, 1'b0);
        check("abort_outs_low", {res_valid, mm_valid_in, a_rd_en, b_rd_en, done}, 5'b0);
        check("abort_err_kept", err_timeout, 1'b0);
        seen_done = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (done || busy) seen_done = 1'b1;
        end
        check("abort_stays_idle", seen_done, 1'b0);
        randomize_mats();
        run_full(-1, 0, -1);

        // Reset during WRITE of the last tile, then a clean run.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 19; t++) tick();
        check("rst_pre_write", {res_valid, res_row, res_col}, 3'b111);
        res_ready = 1'b0;
        rst       = 1'b0;
        tick();
        rst       = 1'b1;
        res_ready = 1'b1;
        check_all_zero("mid_reset");
        randomize_mats();
        run_full(-1, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
